pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter DW, default 32, payload width in bits (legal 1..256).
REQ-002 SHALL have parameter SKID, default 1; 1 = two-entry skid stage with registered in_ready, 0 = single-entry stage with combinational in_ready.
REQ-003 SHALL have parameter CW, default 16, width of each performance counter (legal 4..32).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous kill of all held entries (branch/jump redirect).
REQ-007 SHALL have port in_valid  input  1  upstream entry present.
REQ-008 SHALL have port in_data  input  DW  upstream payload.
REQ-009 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-010 SHALL have port out_valid  output  1  downstream entry present.
REQ-011 SHALL have port out_data  output  DW  downstream payload.
REQ-012 SHALL have port out_ready  input  1  downstream accepts this cycle (stall = low).
REQ-013 SHALL have port stall_cnt  output  CW  cycles with out_valid=1 and out_ready=0.
REQ-014 SHALL have port bubble_cnt  output  CW  cycles with out_valid=0 and out_ready=1.
REQ-015 SHALL have port occupancy  output  2  number of held entries (0..2).

Function
REQ-016 SHALL transfer in when in_valid and in_ready are both 1 at a rising edge; transfer out when out_valid and out_ready are both 1.
REQ-017 SHALL deliver entries in acceptance order, none duplicated or dropped except by flush.
REQ-018 SHALL give one-cycle latency: an entry accepted at edge N with an empty stage appears on out_data after edge N.
REQ-019 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SKID=1: SHALL implement states EMPTY (occupancy 0), ONE (main register full), TWO (main and skid full); in_ready SHALL be a registered signal equal to (state != TWO).
REQ-021 SKID=1 transitions: EMPTY->ONE on in-transfer; ONE->TWO on in-transfer without out-transfer; ONE->EMPTY on out-transfer without in-transfer; ONE stays ONE on simultaneous in/out transfer; TWO->ONE on out-transfer, skid entry moving to main register.
REQ-022 SKID=1: SHALL sustain one transfer per cycle under continuous in_valid=1, out_ready=1.
REQ-023 SKID=0: in_ready SHALL equal (!out_valid | out_ready); skid register SHALL NOT exist; occupancy never exceeds 1.
REQ-024 flush=1 at an edge SHALL clear all entries (state EMPTY, out_valid=0), discard any in-transfer in that cycle, and take priority over all other transitions.
REQ-025 flush SHALL leave counters unchanged; in_ready SHALL be 1 in the cycle after flush.
REQ-026 stall_cnt and bubble_cnt SHALL each increment by 1 per qualifying cycle and saturate at all-ones (no wrap).
REQ-027 Counters SHALL count the cycle of a flush if its condition holds before the edge.
REQ-028 out_data SHALL be don't-care while out_valid=0; implementation SHALL not zero it except at reset.

Reset
REQ-029 While rst=1: state EMPTY, out_valid=0, out_data=0, skid data=0, occupancy=0, stall_cnt=0, bubble_cnt=0; in_ready=1 for SKID=1, combinational value 1 for SKID=0.
REQ-030 rst asserted mid-operation SHALL discard all held entries immediately without waiting for a clock edge.
REQ-031 First transfer after rst deassertion SHALL be accepted on the first rising edge with in_valid=1.

Verification
REQ-032 SKID=1, in_valid=1 data 1,2,3... each cycle, out_ready=1 -> out_data 1,2,3... one cycle later, one per cycle, stall_cnt=0.
REQ-033 SKID=1, accept 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held; out_ready=1 two cycles -> 0xA then 0xB, stall_cnt=2.
REQ-034 SKID=1 state TWO, flush=1 with in_valid=1 data 0xC -> next cycle out_valid=0, occupancy=0, in_ready=1, 0xC never output.
REQ-035 SKID=0, out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> simultaneous in/out transfer, occupancy stays 1.
REQ-036 CW=4, out_valid=0, out_ready=1 for 20 cycles -> bubble_cnt reaches 15 and stays 15.
REQ-037 rst pulsed asynchronously between edges while occupancy=2 -> out_valid=0, counters=0 before next edge.

Source files
------------

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with optional skid entry and
// stall/bubble performance counters.
//
// State table (SKID=1):
//   state    | meaning
//   ST_EMPTY | no entry held, in_ready=1
//   ST_ONE   | main register holds the head entry
//   ST_TWO   | main and skid registers both full, in_ready=0
//
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   flush                 synchronous kill of every held entry
//   in_valid/in_data      upstream entry and payload
//   in_ready              stage accepts an entry this cycle
//   out_valid/out_data    downstream entry and payload
//   out_ready             downstream accepts this cycle
//   stall_cnt             saturating count of out_valid & !out_ready cycles
//   bubble_cnt            saturating count of !out_valid & out_ready cycles
//   occupancy             number of held entries (0..2)
module pipe_stage #(
    parameter int DW   = 32,
    parameter int SKID = 1,
    parameter int CW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] bubble_cnt,
    output logic [1:0]    occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    logic [CW-1:0] stall_q;
    logic [CW-1:0] bubble_q;

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

    // Counters sample the pre-edge handshake, so a flush cycle still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if (!out_valid && out_ready && (bubble_q != '1))
                bubble_q <= bubble_q + 1'b1;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            state_t        state;
            logic [DW-1:0] main_q;
            logic [DW-1:0] skid_q;
            logic          ready_q;
            logic          valid_q;
            logic          in_fire;
            logic          out_fire;

            assign in_fire   = in_valid & ready_q;
            assign out_fire  = valid_q & out_ready;
            assign in_ready  = ready_q;
            assign out_valid = valid_q;
            assign out_data  = main_q;
            assign occupancy = (state == ST_TWO) ? 2'd2 :
                               (state == ST_ONE) ? 2'd1 : 2'd0;

            // Payload registers are only loaded, never cleared outside reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state   <= ST_EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end else if (flush) begin
                    state   <= ST_EMPTY;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                main_q  <= in_data;
                                valid_q <= 1'b1;
                                state   <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (in_fire && out_fire) begin
                                main_q <= in_data;
                            end else if (in_fire) begin
                                skid_q  <= in_data;
                                ready_q <= 1'b0;
                                state   <= ST_TWO;
                            end else if (out_fire) begin
                                valid_q <= 1'b0;
                                state   <= ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            // ready_q is low here, so no in-transfer can coincide.
                            if (out_fire) begin
                                main_q  <= skid_q;
                                ready_q <= 1'b1;
                                state   <= ST_ONE;
                            end
                        end
                        default: begin
                            state   <= ST_EMPTY;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                        end
                    endcase
                end
            end
        end else begin : g_single
            logic [DW-1:0] data_q;
            logic          valid_q;
            logic          in_fire;
            logic          out_fire;

            // Accept whenever the register is empty or being drained this cycle.
            assign in_ready  = !valid_q | out_ready;
            assign in_fire   = in_valid & in_ready;
            assign out_fire  = valid_q & out_ready;
            assign out_valid = valid_q;
            assign out_data  = data_q;
            assign occupancy = {1'b0, valid_q};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (in_fire) begin
                    data_q  <= in_data;
                    valid_q <= 1'b1;
                end else if (out_fire) begin
                    valid_q <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage.sv
`timescale 1ns/1ps
// Bench for pipe_stage: one skid instance (SKID=1, CW=4) and one single-entry
// instance (SKID=0, CW=16), each checked every cycle against a FIFO model.
module tb_pipe_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic [15:0] s_in_data = '0;
    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_data;
    logic [3:0]  s_stall, s_bubble;
    logic [1:0]  s_occ;

    logic        n_flush = 1'b0, n_in_valid = 1'b0, n_out_ready = 1'b0;
    logic [15:0] n_in_data = '0;
    logic        n_in_ready, n_out_valid;
    logic [15:0] n_out_data;
    logic [15:0] n_stall, n_bubble;
    logic [1:0]  n_occ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage #(.DW(16), .SKID(1), .CW(4)) dut_s (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
        .stall_cnt(s_stall), .bubble_cnt(s_bubble), .occupancy(s_occ)
    );

    pipe_stage #(.DW(16), .SKID(0), .CW(16)) dut_n (
        .clk(clk), .rst(rst), .flush(n_flush),
        .in_valid(n_in_valid), .in_data(n_in_data), .in_ready(n_in_ready),
        .out_valid(n_out_valid), .out_data(n_out_data), .out_ready(n_out_ready),
        .stall_cnt(n_stall), .bubble_cnt(n_bubble), .occupancy(n_occ)
    );

    // ---------------- behavioural model: a bounded FIFO per instance ----------
    logic [15:0] m_q      [2][2];
    int          m_cnt    [2];
    int          m_stall  [2];
    int          m_bubble [2];
    int          m_max    [2];

    initial begin
        m_max[0] = 15;
        m_max[1] = 65535;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_stall[i] = 0; m_bubble[i] = 0;
        end
    end

    // Skid instance holds up to two and accepts whenever not full;
    // single instance holds one and accepts when empty or draining.
    function automatic logic m_ready(input int i, input logic ord);
        if (i == 0) return (m_cnt[0] < 2);
        return (m_cnt[1] == 0) || ord;
    endfunction

    task automatic m_step(input int i, input logic fl, input logic iv,
                          input logic [15:0] id, input logic ord);
        logic ifire, ofire;
        ifire = iv && m_ready(i, ord);
        ofire = (m_cnt[i] > 0) && ord;
        if ((m_cnt[i] > 0) && !ord && (m_stall[i] < m_max[i]))   m_stall[i]++;
        if ((m_cnt[i] == 0) && ord && (m_bubble[i] < m_max[i]))  m_bubble[i]++;
        if (fl) begin
            m_cnt[i] = 0;
        end else begin
            if (ofire) begin
                m_q[i][0] = m_q[i][1];
                m_cnt[i]--;
            end
            if (ifire) begin
                m_q[i][m_cnt[i]] = id;
                m_cnt[i]++;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_stall[i] = 0; m_bubble[i] = 0;
            end
        end else begin
            m_step(0, s_flush, s_in_valid, s_in_data, s_out_ready);
            m_step(1, n_flush, n_in_valid, n_in_data, n_out_ready);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("s_in_ready",  32'(s_in_ready),  32'(m_ready(0, s_out_ready)));
        chk("s_out_valid", 32'(s_out_valid), 32'(m_cnt[0] > 0));
        chk("s_occupancy", 32'(s_occ),       32'(m_cnt[0]));
        chk("s_stall_cnt", 32'(s_stall),     32'(m_stall[0]));
        chk("s_bubble_cnt",32'(s_bubble),    32'(m_bubble[0]));
        if (m_cnt[0] > 0) chk("s_out_data", 32'(s_out_data), 32'(m_q[0][0]));
        chk("n_in_ready",  32'(n_in_ready),  32'(m_ready(1, n_out_ready)));
        chk("n_out_valid", 32'(n_out_valid), 32'(m_cnt[1] > 0));
        chk("n_occupancy", 32'(n_occ),       32'(m_cnt[1]));
        chk("n_stall_cnt", 32'(n_stall),     32'(m_stall[1]));
        chk("n_bubble_cnt",32'(n_bubble),    32'(m_bubble[1]));
        if (m_cnt[1] > 0) chk("n_out_data", 32'(n_out_data), 32'(m_q[1][0]));
    end

    // One clock; returns 1 ns after the falling edge so inputs change away from both edges.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        step();
        step();
        chk("rst_s_in_ready",  32'(s_in_ready),  32'd1);
        chk("rst_s_out_data",  32'(s_out_data),  32'd0);
        chk("rst_n_in_ready",  32'(n_in_ready),  32'd1);
        chk("rst_n_out_data",  32'(n_out_data),  32'd0);
        chk("rst_s_occ",       32'(s_occ),       32'd0);
        rst = 1'b0;

        // Streaming: one per cycle, data appears one cycle after acceptance.
        s_out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            s_in_valid = 1'b1;
            s_in_data  = 16'(k);
            step();
            chk("stream_valid", 32'(s_out_valid), 32'd1);
            chk("stream_data",  32'(s_out_data),  32'(k));
        end
        s_in_valid = 1'b0;
        step();
        chk("stream_stall", 32'(s_stall), 32'd0);

        // Fill both registers while stalled, hold, then drain in order.
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 16'h000A;
        step();
        s_in_data   = 16'h000B;
        step();
        s_in_valid  = 1'b0;
        chk("two_occ",      32'(s_occ),      32'd2);
        chk("two_in_ready", 32'(s_in_ready), 32'd0);
        chk("two_head",     32'(s_out_data), 32'h000A);
        step();
        chk("hold_head",    32'(s_out_data), 32'h000A);
        chk("hold_valid",   32'(s_out_valid),32'd1);
        s_out_ready = 1'b1;
        step();
        chk("drain_b",      32'(s_out_data), 32'h000B);
        chk("drain_occ",    32'(s_occ),      32'd1);
        step();
        chk("drain_empty",  32'(s_out_valid),32'd0);
        chk("drain_stall",  32'(s_stall),    32'd2);

        // Flush from TWO with a concurrent in-transfer attempt.
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 16'h0011;
        step();
        s_in_data   = 16'h0022;
        step();
        chk("pre_flush_occ", 32'(s_occ), 32'd2);
        s_flush   = 1'b1;
        s_in_data = 16'h000C;
        step();
        s_flush    = 1'b0;
        s_in_valid = 1'b0;
        chk("flush_valid",    32'(s_out_valid), 32'd0);
        chk("flush_occ",      32'(s_occ),       32'd0);
        chk("flush_in_ready", 32'(s_in_ready),  32'd1);
        chk("flush_stall",    32'(s_stall),     32'd4);
        s_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("flush_no_c", 32'(s_out_valid), 32'd0);
        end

        // Single-entry stage: combinational back-pressure and simultaneous transfer.
        n_out_ready = 1'b0;
        n_in_valid  = 1'b1;
        n_in_data   = 16'h0055;
        step();
        chk("n_valid",    32'(n_out_valid), 32'd1);
        chk("n_ready_lo", 32'(n_in_ready),  32'd0);
        n_in_data = 16'h0066;
        step();
        chk("n_hold",     32'(n_out_data),  32'h0055);
        n_out_ready = 1'b1;
        #1;
        chk("n_ready_hi", 32'(n_in_ready),  32'd1);
        step();
        chk("n_pass",     32'(n_out_data),  32'h0066);
        chk("n_pass_occ", 32'(n_occ),       32'd1);
        n_in_valid = 1'b0;
        step();
        chk("n_empty",    32'(n_out_valid), 32'd0);

        // Bubble counter saturation at CW=4.
        s_out_ready = 1'b1;
        for (int k = 0; k < 20; k++) step();
        chk("bubble_sat",  32'(s_bubble), 32'd15);
        step();
        chk("bubble_stay", 32'(s_bubble), 32'd15);

        // Mixed handshake pattern on both instances.
        for (int k = 0; k < 48; k++) begin
            s_in_valid  = (k % 3) != 0;
            s_in_data   = 16'(16'h0100 + k);
            s_out_ready = (k % 4) != 1;
            n_in_valid  = (k % 5) != 2;
            n_in_data   = 16'(16'h0200 + k);
            n_out_ready = (k % 3) != 0;
            s_flush     = (k == 30);
            n_flush     = (k == 37);
            step();
        end
        s_flush = 1'b0; n_flush = 1'b0;

        // Asynchronous reset between edges while full.
        s_in_valid = 1'b1; s_out_ready = 1'b0; s_in_data = 16'h0077;
        n_in_valid = 1'b1; n_out_ready = 1'b0; n_in_data = 16'h0099;
        step();
        s_in_data = 16'h0088;
        step();
        chk("async_pre_occ", 32'(s_occ), 32'd2);
        s_in_valid = 1'b0; n_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_s_valid",  32'(s_out_valid), 32'd0);
        chk("async_s_occ",    32'(s_occ),       32'd0);
        chk("async_s_stall",  32'(s_stall),     32'd0);
        chk("async_s_bubble", 32'(s_bubble),    32'd0);
        chk("async_s_ready",  32'(s_in_ready),  32'd1);
        chk("async_n_valid",  32'(n_out_valid), 32'd0);
        chk("async_n_stall",  32'(n_stall),     32'd0);
        rst = 1'b0;

        // First edge after reset accepts.
        s_in_valid = 1'b1; s_in_data = 16'h005A; s_out_ready = 1'b1;
        step();
        s_in_valid = 1'b0;
        chk("post_rst_valid", 32'(s_out_valid), 32'd1);
        chk("post_rst_data",  32'(s_out_data),  32'h005A);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
